// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// ALU functions, mux selects and the bundled control-strobe struct.
package mips_ctrl_pkg;

    localparam logic [2:0] S_IF      = 3'b000;
    localparam logic [2:0] S_ID      = 3'b001;
    localparam logic [2:0] S_MEMADDR = 3'b010;
    localparam logic [2:0] S_MEM     = 3'b011;
    localparam logic [2:0] S_LWWB    = 3'b100;
    localparam logic [2:0] S_BR      = 3'b101;
    localparam logic [2:0] S_EXE     = 3'b110;
    localparam logic [2:0] S_WB      = 3'b111;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_PC4 = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic is_itype_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI);
    endfunction

    // Anything not in the ALU table behaves as a plain R-type add.
    function automatic logic [2:0] alu_fn(input logic [5:0] op);
        case (op)
            OP_SUB:         return ALU_SUB;
            OP_OR, OP_ORI:  return ALU_OR;
            OP_AND:         return ALU_AND;
            OP_SLL:         return ALU_SLL;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_transition_checker.sv
// Combinational legality check of a proposed state transition against the
// multi-cycle control graph.
module transition_checker
    import mips_ctrl_pkg::*;
#(
    parameter int ST_W = 3
) (
    input  logic [ST_W-1:0] state,
    input  logic [ST_W-1:0] next_state,
    output logic            legal
);

    always_comb begin
        legal = 1'b0;
        case (state)
            S_IF:      legal = (next_state == S_ID);
            S_ID:      legal = next_state inside {S_BR, S_MEMADDR, S_EXE, S_IF};
            S_EXE:     legal = (next_state == S_WB);
            S_MEMADDR: legal = (next_state == S_MEM);
            S_MEM:     legal = next_state inside {S_IF, S_LWWB};
            default:   legal = (next_state == S_IF); // BR, WB, LWWB
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: state register, opcode latch, transition
// guard, halt and Moore control strobes. Optional counters: PERF_CNT_EN.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int ST_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ST_W-1:0]  next_state,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             zero,
    input  logic             sign,
    output logic [ST_W-1:0]  state,
    output logic [OPC_W-1:0] opcode,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             ext_sel,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal_trans
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      instr_cnt
`endif
);

    logic  legal;
    ctrl_t c;

    transition_checker #(.ST_W(ST_W)) u_chk (
        .state      (state),
        .next_state (next_state),
        .legal      (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IF;
            opcode        <= '0;
            halted        <= 1'b0;
            illegal_trans <= 1'b0;
        end else begin
            illegal_trans <= 1'b0;
            if (halted) begin
                state <= S_IF;
            end else begin
                if (state == S_IF) opcode <= ir_opcode;
                if (state == S_ID && opcode == OP_HALT) begin
                    state  <= S_IF;
                    halted <= 1'b1;
                end else if (legal) begin
                    state <= next_state;
                end else begin
                    state         <= S_IF;
                    illegal_trans <= 1'b1;
                end
            end
        end
    end

    // Strobes are gated by rst so an aborted instruction never writes.
    always_comb begin
        c        = '0;
        c.alu_op = ALU_ADD;
        if (!rst && !halted) begin
            case (state)
                S_IF: begin
                    c.ir_we  = 1'b1;
                    c.mem_rd = 1'b1;
                end
                S_ID: begin
                    case (opcode)
                        OP_J: begin
                            c.pc_we  = 1'b1;
                            c.pc_src = PC_J;
                        end
                        OP_JR: begin
                            c.pc_we  = 1'b1;
                            c.pc_src = PC_JR;
                        end
                        OP_JAL: begin
                            c.pc_we   = 1'b1;
                            c.pc_src  = PC_J;
                            c.reg_we  = 1'b1;
                            c.reg_dst = RD_RA;
                            c.wb_src  = WB_PC4;
                        end
                        default: ;
                    endcase
                end
                S_EXE: begin
                    c.alu_src_b = is_itype_alu(opcode);
                    c.alu_src_a = (opcode == OP_SLL);
                    c.ext_sel   = (opcode == OP_ADDI);
                    c.alu_op    = alu_fn(opcode);
                end
                S_WB: begin
                    c.reg_we  = 1'b1;
                    c.reg_dst = is_itype_alu(opcode) ? RD_RT : RD_RD;
                    c.wb_src  = WB_ALU;
                    c.pc_we   = 1'b1;
                    c.pc_src  = PC_PC4;
                end
                S_BR: begin
                    c.alu_op = ALU_SUB;
                    c.pc_we  = 1'b1;
                    if ((opcode == OP_BEQ  &&  zero) ||
                        (opcode == OP_BNE  && !zero) ||
                        (opcode == OP_BLTZ &&  sign))
                        c.pc_src = PC_BR;
                end
                S_MEMADDR: begin
                    c.alu_src_b = 1'b1;
                    c.ext_sel   = 1'b1;
                    c.alu_op    = ALU_ADD;
                end
                S_MEM: begin
                    c.mem_rd = (opcode == OP_LW);
                    if (opcode == OP_SW) begin
                        c.mem_wr = 1'b1;
                        c.pc_we  = 1'b1;
                        c.pc_src = PC_PC4;
                    end
                end
                S_LWWB: begin
                    c.reg_we  = 1'b1;
                    c.reg_dst = RD_RT;
                    c.wb_src  = WB_MEM;
                    c.pc_we   = 1'b1;
                    c.pc_src  = PC_PC4;
                end
                default: ;
            endcase
        end
    end

    assign pc_we     = c.pc_we;
    assign ir_we     = c.ir_we;
    assign reg_we    = c.reg_we;
    assign mem_rd    = c.mem_rd;
    assign mem_wr    = c.mem_wr;
    assign alu_src_a = c.alu_src_a;
    assign alu_src_b = c.alu_src_b;
    assign ext_sel   = c.ext_sel;
    assign reg_dst   = c.reg_dst;
    assign wb_src    = c.wb_src;
    assign pc_src    = c.pc_src;
    assign alu_op    = c.alu_op;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (!halted) cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we)   instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios then a
// random walk through the state graph, checked against a behavioural model.
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] next_state = '0;
    logic [5:0] ir_opcode = '0;
    logic       zero = 1'b0, sign = 1'b0;
    logic [2:0] state;
    logic [5:0] opcode;
    logic       pc_we, ir_we, reg_we, mem_rd, mem_wr;
    logic       alu_src_a, alu_src_b, ext_sel;
    logic [1:0] reg_dst, wb_src, pc_src;
    logic [2:0] alu_op;
    logic       halted, illegal_trans;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .next_state(next_state), .ir_opcode(ir_opcode),
        .zero(zero), .sign(sign), .state(state), .opcode(opcode),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_sel(ext_sel), .reg_dst(reg_dst), .wb_src(wb_src),
        .pc_src(pc_src), .alu_op(alu_op), .halted(halted),
        .illegal_trans(illegal_trans)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [16:0] ctrl_word;
    assign ctrl_word = {pc_we, ir_we, reg_we, mem_rd, mem_wr, alu_src_a, alu_src_b,
                        ext_sel, reg_dst, wb_src, pc_src, alu_op};

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only.
    logic [2:0] m_st;
    logic [5:0] m_opc;
    logic       m_halt, m_ill;
    logic [5:0] pool [0:14];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal_edge(input logic [2:0] from, input logic [2:0] to);
        case (from)
            S_IF:      return to == S_ID;
            S_ID:      return to inside {S_BR, S_MEMADDR, S_EXE, S_IF};
            S_EXE:     return to == S_WB;
            S_MEMADDR: return to == S_MEM;
            S_MEM:     return to inside {S_IF, S_LWWB};
            default:   return to == S_IF;
        endcase
    endfunction

    // Expected control word plus a mask of the fields the behaviour defines.
    task automatic exp_ctrl(input logic [2:0] st, input logic [5:0] op, input logic z,
                            input logic s, input logic hlt, input logic rs,
                            output logic [16:0] v, output logic [16:0] m);
        logic pw, iw, rw, mr, mw, sa, sb, es, msa, msb, mes, mrd, mwb, mps, mao, itype;
        logic [1:0] rd, wb, ps;
        logic [2:0] ao;
        {pw, iw, rw, mr, mw, sa, sb, es} = '0;
        {msa, msb, mes, mrd, mwb, mps, mao} = '0;
        rd = '0; wb = '0; ps = '0; ao = '0;
        itype = (op == OP_ADDI) || (op == OP_ORI);
        if (!(rs || hlt)) begin
            case (st)
                S_IF: begin iw = 1; mr = 1; end
                S_ID: begin
                    if (op == OP_J)   begin pw = 1; ps = 2'b11; mps = 1; end
                    if (op == OP_JR)  begin pw = 1; ps = 2'b10; mps = 1; end
                    if (op == OP_JAL) begin
                        pw = 1; ps = 2'b11; rw = 1; rd = 2'b00; wb = 2'b10;
                        mps = 1; mrd = 1; mwb = 1;
                    end
                end
                S_EXE: begin
                    sb = itype; sa = (op == OP_SLL); msa = 1; msb = 1;
                    if (itype) begin mes = 1; es = (op == OP_ADDI); end
                    mao = 1;
                    if (op == OP_SUB) ao = ALU_SUB;
                    else if (op == OP_OR || op == OP_ORI) ao = ALU_OR;
                    else if (op == OP_AND) ao = ALU_AND;
                    else if (op == OP_SLL) ao = ALU_SLL;
                    else ao = ALU_ADD;
                end
                S_WB: begin
                    rw = 1; rd = itype ? 2'b01 : 2'b10; wb = 2'b00; pw = 1; ps = 2'b00;
                    mrd = 1; mwb = 1; mps = 1;
                end
                S_BR: begin
                    ao = ALU_SUB; mao = 1; pw = 1; mps = 1;
                    ps = ((op == OP_BEQ && z) || (op == OP_BNE && !z) ||
                          (op == OP_BLTZ && s)) ? 2'b01 : 2'b00;
                end
                S_MEMADDR: begin
                    sb = 1; es = 1; ao = ALU_ADD; msb = 1; mes = 1; mao = 1;
                end
                S_MEM: begin
                    mr = (op == OP_LW);
                    if (op == OP_SW) begin mw = 1; pw = 1; ps = 2'b00; mps = 1; end
                end
                default: begin // LWWB
                    rw = 1; rd = 2'b01; wb = 2'b01; pw = 1; ps = 2'b00;
                    mrd = 1; mwb = 1; mps = 1;
                end
            endcase
        end
        v = {pw, iw, rw, mr, mw, sa, sb, es, rd, wb, ps, ao};
        m = {5'h1f, msa, msb, mes, {2{mrd}}, {2{mwb}}, {2{mps}}, {3{mao}}};
    endtask

    task automatic check_now(input string tag);
        logic [16:0] v, m;
        exp_ctrl(m_st, m_opc, zero, sign, m_halt, rst, v, m);
        chk({tag, ".ctrl"}, {15'd0, ctrl_word & m}, {15'd0, v & m});
        chk({tag, ".excl"}, {31'd0, mem_wr & reg_we}, 32'd0);
        chk({tag, ".state"}, {29'd0, state}, {29'd0, m_st});
        chk({tag, ".opcode"}, {26'd0, opcode}, {26'd0, m_opc});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
        chk({tag, ".illegal"}, {31'd0, illegal_trans}, {31'd0, m_ill});
    endtask

    // Called at a falling edge; leaves time at the next falling edge.
    task automatic step(input string tag, input logic [2:0] ns, input logic [5:0] op,
                        input logic z, input logic s);
        next_state = ns; ir_opcode = op; zero = z; sign = s;
        #1;
        check_now(tag);
        @(posedge clk);
        if (m_halt) begin
            m_st = S_IF; m_ill = 0;
        end else begin
            if (m_st == S_IF) m_opc = op;
            if (m_st == S_ID && m_opc == OP_HALT) begin
                m_st = S_IF; m_halt = 1; m_ill = 0;
            end else if (legal_edge(m_st, ns)) begin
                m_st = ns; m_ill = 0;
            end else begin
                m_st = S_IF; m_ill = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_st = S_IF; m_opc = '0; m_halt = 0; m_ill = 0;
        #1;
        check_now("rst_async");
        @(posedge clk);
        #1;
        check_now("rst_hold");
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [2:0] plan_next(input logic [2:0] st, input logic [5:0] op);
        case (st)
            S_IF:      return S_ID;
            S_ID: begin
                if (op == OP_LW || op == OP_SW) return S_MEMADDR;
                if (op inside {OP_BEQ, OP_BNE, OP_BLTZ}) return S_BR;
                if (op inside {OP_J, OP_JR, OP_JAL}) return S_IF;
                return S_EXE;
            end
            S_EXE:     return S_WB;
            S_MEMADDR: return S_MEM;
            S_MEM:     return (op == OP_LW) ? S_LWWB : S_IF;
            default:   return S_IF;
        endcase
    endfunction

    initial begin
        logic [5:0] op;
        logic [2:0] ns;
        pool = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SW,
                 OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR, OP_JAL};
        @(negedge clk);
        do_reset();

        // R-type add: IF -> ID -> EXE -> WB -> IF
        step("add_if",  S_ID,  OP_ADD, 0, 0);
        step("add_id",  S_EXE, OP_ADD, 0, 0);
        step("add_exe", S_WB,  OP_ADD, 0, 0);
        chk("add_wb_reg_dst", {30'd0, reg_dst}, 32'd2);
        step("add_wb",  S_IF,  OP_ADD, 0, 0);

        // Load path
        step("lw_if",   S_ID,      OP_LW, 0, 0);
        step("lw_id",   S_MEMADDR, OP_LW, 0, 0);
        step("lw_ma",   S_MEM,     OP_LW, 0, 0);
        step("lw_mem",  S_LWWB,    OP_LW, 0, 0);
        step("lw_wb",   S_IF,      OP_LW, 0, 0);

        // Branches
        step("beq_if",  S_ID, OP_BEQ, 0, 0);
        step("beq_id",  S_BR, OP_BEQ, 0, 0);
        step("beq_t",   S_IF, OP_BEQ, 1, 0);
        step("beq2_if", S_ID, OP_BEQ, 0, 0);
        step("beq2_id", S_BR, OP_BEQ, 0, 0);
        step("beq_nt",  S_IF, OP_BEQ, 0, 1);
        step("bltz_if", S_ID, OP_BLTZ, 0, 0);
        step("bltz_id", S_BR, OP_BLTZ, 0, 0);
        step("bltz_t",  S_IF, OP_BLTZ, 0, 1);

        // Illegal EXE -> MEM
        step("ill_if",  S_ID,  OP_ORI, 0, 0);
        step("ill_id",  S_EXE, OP_ORI, 0, 0);
        step("ill_exe", S_MEM, OP_ORI, 0, 0);
        step("ill_post", S_ID, OP_ADD, 0, 0);
        step("ill_gone", S_EXE, OP_ADD, 0, 0);

        // Halt
        do_reset();
        step("halt_if", S_ID, OP_HALT, 0, 0);
        step("halt_id", S_BR, OP_HALT, 0, 0);
        for (int i = 0; i < 6; i++) begin
            ns = 3'($urandom);
            step("halted", ns, 6'($urandom), 1'($urandom), 1'($urandom));
        end
        do_reset();

        // Reset in the middle of a store's MEM cycle
        step("sw_if", S_ID,      OP_SW, 0, 0);
        step("sw_id", S_MEMADDR, OP_SW, 0, 0);
        step("sw_ma", S_MEM,     OP_SW, 0, 0);
        next_state = S_IF;
        #1;
        chk("sw_mem_wr", {31'd0, mem_wr}, 32'd1);
        #3;
        do_reset();
        chk("sw_rst_mem_wr", {31'd0, mem_wr}, 32'd0);

        // Random walk through the graph with occasional bad successors
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                if (op == OP_HALT) op = OP_ADD;
            end else begin
                op = pool[$urandom_range(0, 14)];
            end
            ns = plan_next(m_st, m_opc);
            if ($urandom_range(0, 15) == 0) ns = 3'($urandom);
            step("rand", ns, op, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
